// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

  localparam int unsigned WORD_W              = 32;
  localparam int unsigned STRB_W              = 4;
  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Misaligned or beyond the last word; indices never wrap.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || (32'(a[ADDR_W-1:2]) >= depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: byte-enabled synchronous write, combinational read.
module mem_array
  import mem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int unsigned IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [WORD_W-1:0] rdata_c
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata_c = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Request/response front end: latches one request, waits WAIT_CYCLES, then
// answers with a one-cycle ready pulse carrying read data or an error.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              bad_q, bad_d;
  logic              ready_d, err_d, busy_d;
  logic [WORD_W-1:0] rdata_d;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .idx     (IDX_W'(req_q.addr >> 2)),
    .wdata   (req_q.wdata),
    .wstrb   (req_q.wstrb),
    .rdata_c (mem_rdata)
  );

  // Next state, request latch and response outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    bad_d   = bad_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          req_d   = '{we: we, addr: addr, wdata: wdata, wstrb: wstrb};
          bad_d   = addr_bad(addr, DEPTH_WORDS);
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
        err_d   = bad_q;
        // Storage commits at the edge that ends RESP; errored requests never touch it.
        mem_we  = req_q.we && !bad_q;
        if (!req_q.we && !bad_q) rdata_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      bad_q   <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      bad_q   <= bad_d;
      ready   <= ready_d;
      err     <= err_d;
      rdata   <= rdata_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default-wait instance plus a zero-wait instance.
module tb_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready, err, busy;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  wstrb0 = '0;
  logic [31:0] rdata0;
  logic        ready0, err0, busy0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .wstrb(wstrb0), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  // Issue one request at the current negedge and collect the response (no checking here).
  task automatic txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                     input logic [3:0] t_wstrb, output int lat, output int busy_n,
                     output logic [31:0] rd, output logic e);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; wstrb = t_wstrb;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    lat = -1; busy_n = 0; rd = '0; e = 1'b0;
    for (int n = 0; n < 16 && lat < 0; n++) begin
      if (n > 0) @(negedge clk);
      if (busy) busy_n++;
      if (ready) begin lat = n; rd = rdata; e = err; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b want 0", ready); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", rdata); end
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    int lat, bn; logic [31:0] rd; logic e;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, bn, rd, e);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL wr_latency got %0d want 3", lat); end
    vectors++; if (bn !== 3) begin miscompares++; $display("FAIL wr_busy_cycles got %0d want 3", bn); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL wr_err got %b want 0", e); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL wr_rdata got %h want 0", rd); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rd_latency got %0d want 3", lat); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", rd); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL rd_err got %b want 0", e); end
  endtask

  task automatic test_strobes();
    int lat, bn; logic [31:0] rd; logic e;
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, bn, rd, e);
    txn(1'b0, 32'h10, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (rd !== 32'hDEADBEAA) begin miscompares++; $display("FAIL strb0001 got %h want deadbeaa", rd); end
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, bn, rd, e);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL strb0000_ready got %0d want 3", lat); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL strb0000_err got %b want 0", e); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (rd !== 32'hDEADBEAA) begin miscompares++; $display("FAIL strb0000_data got %h want deadbeaa", rd); end
    txn(1'b1, 32'h14, 32'h11223344, 4'hF, lat, bn, rd, e);
    txn(1'b1, 32'h14, 32'hAABBCCDD, 4'b1010, lat, bn, rd, e);
    txn(1'b0, 32'h14, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (rd !== 32'hAA22CC44) begin miscompares++; $display("FAIL strb1010 got %h want aa22cc44", rd); end
  endtask

  task automatic test_errors();
    int lat, bn; logic [31:0] rd; logic e;
    txn(1'b0, 32'h12, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL misalign_ready got %0d want 3", lat); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL misalign_err got %b want 1", e); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL misalign_rdata got %h want 0", rd); end
    txn(1'b0, DEPTH * 4, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL range_err got %b want 1", e); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL range_rdata got %h want 0", rd); end
    txn(1'b1, DEPTH * 4 - 4, 32'hCAFEF00D, 4'hF, lat, bn, rd, e);
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL last_word_err got %b want 0", e); end
    txn(1'b0, DEPTH * 4 - 4, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL last_word got %h want cafef00d", rd); end
    txn(1'b1, 32'h0, 32'h01020304, 4'hF, lat, bn, rd, e);
    txn(1'b1, DEPTH * 4, 32'h55555555, 4'hF, lat, bn, rd, e);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL range_wr_err got %b want 1", e); end
    txn(1'b0, 32'h0, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (rd !== 32'h01020304) begin miscompares++; $display("FAIL no_alias got %h want 01020304", rd); end
    txn(1'b1, 32'h11, 32'h99999999, 4'hF, lat, bn, rd, e);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL misalign_wr_err got %b want 1", e); end
    txn(1'b0, 32'h10, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (rd !== 32'hDEADBEAA) begin miscompares++; $display("FAIL err_no_update got %h want deadbeaa", rd); end
  endtask

  // req held high: acceptances every WAITC+2 edges, ready at n%4==3.
  task automatic test_back_to_back();
    logic exp_ready, exp_busy;
    int pulses = 0;
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk);
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      exp_ready = (n < 20) && ((n % 4) == 3);
      exp_busy  = (n < 19) && ((n % 4) != 3);
      if (ready) pulses++;
      vectors++; if (ready !== exp_ready) begin miscompares++; $display("FAIL b2b_ready n=%0d got %b want %b", n, ready, exp_ready); end
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL b2b_busy n=%0d got %b want %b", n, busy, exp_busy); end
      if (exp_ready) begin
        vectors++; if (rdata !== 32'hDEADBEAA) begin miscompares++; $display("FAIL b2b_rdata n=%0d got %h want deadbeaa", n, rdata); end
      end
      if (n == 19) begin req = 1'b0; addr = '0; end
    end
    vectors++; if (pulses !== 5) begin miscompares++; $display("FAIL b2b_pulses got %0d want 5", pulses); end
  endtask

  task automatic test_reset_abort();
    int lat, bn; logic [31:0] rd; logic e;
    int pulses = 0;
    txn(1'b1, 32'h20, 32'h0BADF00D, 4'hF, lat, bn, rd, e);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_in_wait got %b want 1", busy); end
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin @(negedge clk); if (ready) pulses++; end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin @(negedge clk); if (ready) pulses++; end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL abort_ready_pulses got %0d want 0", pulses); end
    txn(1'b0, 32'h20, 32'h0, 4'h0, lat, bn, rd, e);
    vectors++; if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL abort_no_write got %h want 0badf00d", rd); end
  endtask

  task automatic test_zero_wait();
    int busy_n = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h13579BDF; wstrb0 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0; we0 = 1'b0; wdata0 = '0; wstrb0 = '0;
    @(negedge clk); @(negedge clk);
    req0 = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 0) req0 = 1'b0;
      if (busy0) busy_n++;
      vectors++; if (ready0 !== (n == 1)) begin miscompares++; $display("FAIL zw_ready n=%0d got %b want %b", n, ready0, (n == 1)); end
      if (n == 1) begin
        vectors++; if (rdata0 !== 32'h13579BDF) begin miscompares++; $display("FAIL zw_rdata got %h want 13579bdf", rdata0); end
        vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL zw_err got %b want 0", err0); end
      end
    end
    vectors++; if (busy_n !== 1) begin miscompares++; $display("FAIL zw_busy_cycles got %0d want 1", busy_n); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
